// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the push-button/switch debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } deb_state_t;

    // 10 ms at 100 MHz.
    localparam int DEFAULT_STABLE_CYCLES = 1000000;

    function automatic int cnt_width(input int stable);
        return $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: two-flop synchroniser, qualification FSM with
// stability counter, registered level and one-cycle rise/fall strobes.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic x_raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             CW      = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    logic          meta_q;
    logic          sync_q;
    deb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          level_q, level_d;
    logic          rise_q,  rise_d;
    logic          fall_q,  fall_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the synchroniser.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            state_q <= LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            meta_q  <= x_raw_i;
            sync_q  <= meta_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            LOW: begin
                if (sync_q) begin
                    state_d = RISE_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            RISE_WAIT: begin
                if (!sync_q) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (!sync_q) begin
                    state_d = FALL_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            FALL_WAIT: begin
                if (sync_q) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/button_debounce.sv
// Multi-channel input conditioner: N_CH fully independent debounce channels
// feeding the edge-to-pulse stage and run/step controls.
module button_debounce
    import debounce_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [N_CH-1:0] x_raw,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_ch (
            .clk_i   (CLK),
            .rst_i   (reset),
            .x_raw_i (x_raw[g]),
            .level_o (level[g]),
            .rise_o  (rise[g]),
            .fall_o  (fall[g])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce with N_CH=2, STABLE_CYCLES=4.
module tb_button_debounce;

    localparam int N_CH = 2;
    localparam int SC   = 4;
    localparam int LAT  = SC + 2;

    logic            CLK   = 1'b0;
    logic            reset = 1'b1;
    logic [N_CH-1:0] x_raw = '0;
    logic [N_CH-1:0] level, rise, fall;

    button_debounce #(
        .N_CH          (N_CH),
        .STABLE_CYCLES (SC)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .x_raw (x_raw),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int              at_edge;
        logic [N_CH-1:0] lvl;
        logic [N_CH-1:0] r;
        logic [N_CH-1:0] f;
    } exp_t;

    exp_t            sb[$];
    exp_t            e;
    int              n_checks = 0;
    int              n_fail   = 0;
    logic [N_CH-1:0] prev_level = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Input changed at this negedge is first sampled on edge cyc+1.
    task automatic drive_expect(input logic [N_CH-1:0] v, input logic [N_CH-1:0] l,
                                input logic [N_CH-1:0] r, input logic [N_CH-1:0] f);
        x_raw = v;
        sb.push_back('{cyc + 1 + LAT, l, r, f});
    endtask

    // Monitor: level may only move together with a strobe; every strobe
    // cycle is matched against the next scoreboard entry.
    always @(negedge CLK) begin
        if (!reset) begin
            check("level_only_with_strobe", 32'((level ^ prev_level) & ~(rise | fall)), 32'd0);
            if ((rise | fall) != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", {28'd0, rise, fall}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ev_edge",  cyc,   e.at_edge);
                    check("ev_level", level, e.lvl);
                    check("ev_rise",  rise,  e.r);
                    check("ev_fall",  fall,  e.f);
                end
            end
        end
        prev_level = level;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with inputs high, then fresh 0->1 after release
        reset = 1'b1;
        x_raw = 2'b11;
        repeat (3) begin
            step(1);
            check("rst_level", level, 0);
            check("rst_rise",  rise,  0);
            check("rst_fall",  fall,  0);
        end
        reset = 1'b0;
        sb.push_back('{cyc + 7, 2'b11, 2'b11, 2'b00});
        step(10);

        // Return both channels low
        drive_expect(2'b00, 2'b00, 2'b00, 2'b11);
        step(10);

        // 2: clean press on ch0
        drive_expect(2'b01, 2'b01, 2'b01, 2'b00);
        step(10);

        // 3: release, then bouncy press on ch0
        drive_expect(2'b00, 2'b00, 2'b00, 2'b01);
        step(10);
        x_raw = 2'b01; step(3);
        x_raw = 2'b00; step(1);
        x_raw = 2'b01; step(2);
        x_raw = 2'b00; step(1);
        drive_expect(2'b01, 2'b01, 2'b01, 2'b00);
        step(10);

        // 4: 4-cycle low glitch rejected; 5-cycle low accepted, then re-press
        x_raw = 2'b00; step(4);
        x_raw = 2'b01; step(10);
        check("glitch_level_held", level, 2'b01);
        drive_expect(2'b00, 2'b00, 2'b00, 2'b01);
        step(5);
        drive_expect(2'b01, 2'b01, 2'b01, 2'b00);
        step(10);

        // 5: simultaneous channels
        drive_expect(2'b00, 2'b00, 2'b00, 2'b01);
        step(10);
        drive_expect(2'b11, 2'b11, 2'b11, 2'b00);
        step(10);
        drive_expect(2'b10, 2'b10, 2'b00, 2'b01);
        step(10);

        // 6: async reset while ch0 is mid-count (cnt=3) and ch1 is HIGH
        x_raw = 2'b11;
        step(5);
        check("pre_reset_level", level, 2'b10);
        #2 reset = 1'b1;
        #1;
        check("async_rst_level", level, 0);
        check("async_rst_rise",  rise,  0);
        check("async_rst_fall",  fall,  0);
        step(2);
        check("held_rst_level", level, 0);
        reset = 1'b0;
        sb.push_back('{cyc + 7, 2'b11, 2'b11, 2'b00});
        step(12);

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
